// File: rtl/vga_sync_decoder.sv
// Purpose : recovers VGA line/frame timing from active-low Hsync/Vsync, qualifies lock, regenerates pixel coordinates and DE.
// Latency : sync pin edge -> internal fall pulse 2 clk; counters -> de/pix_x/pix_y 1 clk; lock loss -> sync_err same edge, locked low 1 clk later.
// Backpressure: none; free-running pixel-rate stream, consumers must accept every clock.
//
// Ports:
//   clk, reset          pixel clock, asynchronous active-low reset
//   hsync_in, vsync_in  asynchronous active-low sync pulses
//   pix_x, pix_y        active-area coordinates (0 outside the active window)
//   de, locked          data enable (locked and in window), timing lock
//   line_len            clocks between the last two Hsync falling edges
//   frame_lines         Hsync falls between the last two Vsync falling edges
//   sync_err            single-cycle pulse when lock is lost
module vga_sync_decoder #(
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        de,
    output logic        locked,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic        sync_err
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [11:0] H_LO   = 12'(H_ACT_START);
    localparam logic [11:0] H_HI   = 12'(H_ACT_START + H_ACTIVE);
    localparam logic [10:0] V_LO   = 11'(V_ACT_START);
    localparam logic [10:0] V_HI   = 11'(V_ACT_START + V_ACTIVE);
    localparam logic [2:0]  LOCK_N = 3'(LOCK_FRAMES);

    logic        hs_meta_q, hs_sync_q, hs_dly_q;
    logic        vs_meta_q, vs_sync_q, vs_dly_q;
    logic        hs_fall, vs_fall;

    logic [11:0] hcnt_q, hcnt_d, hcnt_meas;
    logic [11:0] line_len_q, line_len_d;
    logic [11:0] ref_line_q, ref_line_d;
    logic [10:0] vcnt_q, vcnt_d, vcnt_inc, frame_cap;
    logic [10:0] frame_lines_q, frame_lines_d;
    logic [10:0] ref_frame_q, ref_frame_d;
    logic [2:0]  good_cnt_q, good_cnt_d;
    logic        bad_q, bad_d;
    state_t      state_q, state_d;
    logic        sync_err_q, sync_err_d;
    logic        locked_q;
    logic        de_q, de_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        line_mis, hs_lost, h_act, v_act;

    // Synchronizers idle high so that reset release never looks like a sync edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_meta_q <= 1'b1;
            hs_sync_q <= 1'b1;
            hs_dly_q  <= 1'b1;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_dly_q  <= 1'b1;
        end else begin
            hs_meta_q <= hsync_in;
            hs_sync_q <= hs_meta_q;
            hs_dly_q  <= hs_sync_q;
            vs_meta_q <= vsync_in;
            vs_sync_q <= vs_meta_q;
            vs_dly_q  <= vs_sync_q;
        end
    end

    assign hs_fall = hs_dly_q & ~hs_sync_q;
    assign vs_fall = vs_dly_q & ~vs_sync_q;

    // Measurement counters. hcnt_meas is the length of the line ending now;
    // frame_cap counts a coincident Hsync fall as the last line of the frame.
    always_comb begin
        hcnt_meas     = (hcnt_q == 12'hFFF) ? hcnt_q : hcnt_q + 12'd1;
        vcnt_inc      = (vcnt_q == 11'h7FF) ? vcnt_q : vcnt_q + 11'd1;
        frame_cap     = hs_fall ? vcnt_inc : vcnt_q;
        hcnt_d        = hs_fall ? 12'd0 : hcnt_meas;
        line_len_d    = hs_fall ? hcnt_meas : line_len_q;
        vcnt_d        = vs_fall ? 11'd0 : (hs_fall ? vcnt_inc : vcnt_q);
        frame_lines_d = vs_fall ? frame_cap : frame_lines_q;
        line_mis      = hs_fall && (hcnt_meas != ref_line_q);
        hs_lost       = (hcnt_q == 12'hFFF);
    end

    // Lock qualification.
    always_comb begin
        state_d     = state_q;
        ref_line_d  = ref_line_q;
        ref_frame_d = ref_frame_q;
        good_cnt_d  = good_cnt_q;
        bad_d       = bad_q;
        sync_err_d  = 1'b0;
        case (state_q)
            SEARCH: begin
                // A zero line length means no Hsync yet: nothing to reference.
                if (vs_fall && line_len_q != 12'd0) begin
                    ref_line_d  = line_len_q;
                    ref_frame_d = frame_cap;
                    good_cnt_d  = 3'd0;
                    bad_d       = 1'b0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                bad_d = bad_q | line_mis;
                if (hs_lost) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    bad_d = 1'b0;
                    if (frame_cap == ref_frame_q && !(bad_q || line_mis)) begin
                        good_cnt_d = good_cnt_q + 3'd1;
                        if (good_cnt_d >= LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (line_mis || hs_lost || (vs_fall && frame_cap != ref_frame_q)) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Output window is qualified by the registered lock flag, so DE trails
    // the state machine by one clock in both directions.
    always_comb begin
        h_act   = (hcnt_q >= H_LO) && (hcnt_q < H_HI);
        v_act   = (vcnt_q >= V_LO) && (vcnt_q < V_HI);
        de_d    = locked_q && h_act && v_act;
        pix_x_d = de_d ? 10'(hcnt_q - H_LO) : 10'd0;
        pix_y_d = de_d ? 10'(vcnt_q - V_LO) : 10'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q        <= 12'd0;
            vcnt_q        <= 11'd0;
            line_len_q    <= 12'd0;
            frame_lines_q <= 11'd0;
            ref_line_q    <= 12'd0;
            ref_frame_q   <= 11'd0;
            good_cnt_q    <= 3'd0;
            bad_q         <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
            de_q          <= 1'b0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            ref_line_q    <= ref_line_d;
            ref_frame_q   <= ref_frame_d;
            good_cnt_q    <= good_cnt_d;
            bad_q         <= bad_d;
            sync_err_q    <= sync_err_d;
            locked_q      <= (state_q == LOCKED);
            de_q          <= de_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign de          = de_q;
    assign locked      = locked_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Purpose : directed bench for vga_sync_decoder using a scaled-down raster (64 clk lines, 24-line frames).
// Latency : observes outputs 1 time unit after each rising edge.
// Backpressure: none; the raster generator free-runs.
module tb_vga_sync_decoder;

    localparam int H_TOT = 64;
    localparam int HS_W  = 8;
    localparam int V_TOT = 24;
    localparam int VS_W  = 2;
    localparam int HA_S  = 16;
    localparam int HA_N  = 40;
    localparam int VA_S  = 4;
    localparam int VA_N  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [9:0]  pix_x, pix_y;
    logic        de, locked, sync_err;
    logic [11:0] line_len;
    logic [10:0] frame_lines;

    vga_sync_decoder #(
        .H_ACT_START(HA_S), .H_ACTIVE(HA_N),
        .V_ACT_START(VA_S), .V_ACTIVE(VA_N),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pix_x(pix_x), .pix_y(pix_y), .de(de), .locked(locked),
        .line_len(line_len), .frame_lines(frame_lines), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Raster generator state; starts on the last clock of a frame.
    int gh = H_TOT - 1;
    int gv = V_TOT - 1;
    int cur_hlen = H_TOT;
    int cur_vlen = V_TOT;
    int vlen_next = V_TOT;
    bit short_pend = 1'b0;
    bit hold = 1'b0;

    // Output monitor accumulators.
    int de_cnt, run_cnt, exp_px, px_err, py_err, zero_err, first_de_pos;
    int err_cnt, err_width;
    bit prev_de, prev_err, locked_at_err, locked_after_err, de_after_err;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        de_cnt = 0; run_cnt = 0; exp_px = 0; px_err = 0; py_err = 0; zero_err = 0;
        first_de_pos = -1; err_cnt = 0; err_width = 0;
        prev_de = 1'b0; prev_err = 1'b0;
        locked_at_err = 1'b0; locked_after_err = 1'b1; de_after_err = 1'b1;
    endtask

    // One clock: sample outputs, then advance the raster and drive the pins.
    task automatic step();
        @(posedge clk);
        #1;
        if (de) begin
            de_cnt++;
            if (!prev_de) begin
                run_cnt++;
                exp_px = 0;
                if (first_de_pos < 0) first_de_pos = gv * H_TOT + gh;
            end
            if (pix_x !== exp_px[9:0]) px_err++;
            if (pix_y !== 10'(run_cnt - 1)) py_err++;
            exp_px++;
        end else if (pix_x !== 10'd0 || pix_y !== 10'd0) begin
            zero_err++;
        end
        if (prev_err) begin
            locked_after_err = locked;
            de_after_err     = de;
        end
        if (sync_err) begin
            err_cnt++;
            locked_at_err = locked;
            if (prev_err) err_width++;
        end
        prev_de  = de;
        prev_err = sync_err;

        gh++;
        if (gh >= cur_hlen) begin
            gh = 0;
            gv++;
            cur_hlen = short_pend ? H_TOT - 1 : H_TOT;
            short_pend = 1'b0;
            if (gv >= cur_vlen) begin
                gv = 0;
                cur_vlen = vlen_next;
                vlen_next = V_TOT;
            end
        end
        hsync_in = hold ? 1'b1 : (gh >= HS_W);
        vsync_in = hold ? 1'b1 : (gv >= VS_W);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Returns just after the clock on which both sync pins were driven low.
    task automatic wait_frame_start(input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(gh == 0 && gv == 0) && n < 4000);
        check(tag, int'(gh == 0 && gv == 0), 1);
    endtask

    // Holds reset from now until just before the next frame start.
    task automatic reset_until_frame_end(input string tag);
        int n = 0;
        #1 reset = 1'b0;
        do begin
            step();
            n++;
        end while (!(gv == cur_vlen - 1 && gh == cur_hlen - 4) && n < 4000);
        check(tag, int'(gv == cur_vlen - 1 && gh == cur_hlen - 4), 1);
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_x"}, pix_x, 0);
        check({tag, "_pix_y"}, pix_y, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_line_len"}, line_len, 0);
        check({tag, "_frame_lines"}, frame_lines, 0);
        check({tag, "_sync_err"}, sync_err, 0);
    endtask

    initial begin
        int n;
        clear_mon();

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Clean raster: first fall has no line length, then 1 search + 2 check frames.
        wait_frame_start("fs_A");
        wait_frame_start("fs_B");
        run(8);
        check("lock_B", locked, 0);
        wait_frame_start("fs_C");
        run(8);
        check("lock_C", locked, 0);
        wait_frame_start("fs_D");
        check("lock_D_before", locked, 0);
        run(8);
        check("lock_D_after", locked, 1);
        check("line_len", line_len, H_TOT);
        check("frame_lines", frame_lines, V_TOT);

        // One full locked frame of pixel output.
        clear_mon();
        run(H_TOT * V_TOT);
        check("de_count", de_cnt, HA_N * VA_N);
        check("de_lines", run_cnt, VA_N);
        check("pix_x_seq_err", px_err, 0);
        check("pix_y_seq_err", py_err, 0);
        check("pix_zero_outside", zero_err, 0);
        check("first_de_pos", first_de_pos, VA_S * H_TOT + HA_S + 3);
        check("no_err_clean", err_cnt, 0);

        // Single short line while locked.
        run(10 * H_TOT);
        clear_mon();
        short_pend = 1'b1;
        n = 0;
        while (err_cnt == 0 && n < 300) begin
            step();
            n++;
        end
        run(3);
        check("glitch_err_count", err_cnt, 1);
        check("glitch_err_width", err_width, 0);
        check("glitch_locked_at_err", locked_at_err, 1);
        check("glitch_locked_after", locked_after_err, 0);
        check("glitch_de_after", de_after_err, 0);
        check("glitch_line_len", line_len, H_TOT - 1);
        wait_frame_start("g_G1");
        run(8);
        check("relock_G1", locked, 0);
        wait_frame_start("g_G2");
        run(8);
        check("relock_G2", locked, 0);
        wait_frame_start("g_G3");
        check("relock_G3_before", locked, 0);
        run(8);
        check("relock_G3_after", locked, 1);
        check("glitch_no_more_err", err_cnt, 1);

        // Reset mid-frame while locked.
        run(600);
        check("pre_reset_locked", locked, 1);
        #1 reset = 1'b0;
        #1;
        check_all_zero("midreset");
        reset = 1'b1;
        reset_until_frame_end("rst1_release");
        wait_frame_start("r_A");
        wait_frame_start("r_B");
        wait_frame_start("r_C");
        run(8);
        check("rst_lock_C", locked, 0);
        wait_frame_start("r_D");
        check("rst_lock_D_before", locked, 0);
        run(8);
        check("rst_lock_D_after", locked, 1);

        // Short frame while qualifying: back to search, no error pulse.
        reset_until_frame_end("rst2_release");
        wait_frame_start("s_A");
        clear_mon();
        vlen_next = V_TOT - 1;
        wait_frame_start("s_B");
        run(8);
        check("short_lock_B", locked, 0);
        wait_frame_start("s_C");
        run(8);
        check("short_frame_lines", frame_lines, V_TOT - 1);
        check("short_lock_C", locked, 0);
        check("short_no_err", err_cnt, 0);
        wait_frame_start("s_D");
        run(8);
        check("short_lock_D", locked, 0);
        wait_frame_start("s_E");
        run(8);
        check("short_lock_E", locked, 0);
        wait_frame_start("s_F");
        check("short_lock_F_before", locked, 0);
        run(8);
        check("short_lock_F_after", locked, 1);
        check("short_frame_lines_F", frame_lines, V_TOT);
        check("short_no_err_end", err_cnt, 0);

        // Sync lost entirely: line counter saturates and drops lock.
        clear_mon();
        hold = 1'b1;
        n = 0;
        while (err_cnt == 0 && n < 5000) begin
            step();
            n++;
        end
        check("hold_err_seen", err_cnt, 1);
        check("hold_err_delay", int'(n >= 3990 && n <= 4110), 1);
        step();
        check("hold_locked_after", locked, 0);
        check("hold_line_len", line_len, H_TOT);
        check("hold_frame_lines", frame_lines, V_TOT);
        run(20);
        check("hold_single_err", err_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receiver-side VGA timing recovery: samples incoming active-low Hsync/Vsync and measures line length (clocks) and frame length (lines).
- Qualifies lock over consecutive stable frames, then regenerates pixel coordinates and a data-enable window.
- Sits between the sync pins or generator outputs and downstream pixel consumers such as the capture/overlay logic and the Pong renderer.

Parameters:
- H_ACT_START, 144, first active clock after the Hsync falling edge (sync + back porch).
- H_ACTIVE, 640, active pixels per line.
- V_ACT_START, 35, first active line after the Vsync falling edge.
- V_ACTIVE, 480, active lines per frame.
- LOCK_FRAMES, 2, consecutive matching frames required for lock.

Ports:
- clk  input  1  pixel-rate clock.
- reset  input  1  asynchronous, active-low reset.
- hsync_in  input  1  asynchronous Hsync, active-low pulse.
- vsync_in  input  1  asynchronous Vsync, active-low pulse.
- pix_x  output  10  active-area column; 0 outside active area.
- pix_y  output  10  active-area row; 0 outside active area.
- de  output  1  data enable: locked and inside active window.
- locked  output  1  timing locked.
- line_len  output  12  clocks between the last two Hsync falling edges.
- frame_lines  output  11  Hsync falls between the last two Vsync falling edges.
- sync_err  output  1  one-cycle pulse when lock is lost.

Behaviour:
- Reset (async, active-low):
  - All flops cleared; state = SEARCH.
  - pix_x = 0, pix_y = 0, de = 0, locked = 0, line_len = 0, frame_lines = 0, sync_err = 0.
  - Synchronizer flops reset to 1 (idle-high sync).
- Synchronizer: each sync input passes through 2 flops, then a third delay flop.
  - hs_fall = delayed & ~synced; vs_fall likewise.
  - Input edge to fall pulse: 2 clocks.
- Horizontal counter hcnt (12b):
  - On hs_fall: hcnt <= 0, line_len <= hcnt+1.
  - Otherwise hcnt increments, saturating at 4095.
- Vertical counter vcnt (11b):
  - On hs_fall: increments, saturating at 2047.
  - On vs_fall: vcnt <= 0, frame_lines <= vcnt; vs_fall overrides a simultaneous hs_fall increment.
  - hcnt still clears on a simultaneous hs_fall.
- References ref_line and ref_frame are latched in SEARCH.
- FSM states SEARCH, CHECK, LOCKED; good_cnt 3b.
  - SEARCH, on vs_fall: ref_line <= line_len; ref_frame <= frame value being captured; good_cnt <= 0; go to CHECK. If line_len == 0 (no Hsync seen), stay in SEARCH.
  - CHECK:
    - A line mismatch is any hs_fall with measured length (hcnt+1) != ref_line. It sets the bad flag for the current frame.
    - On vs_fall: if the captured frame length == ref_frame and bad is clear, good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED.
    - Otherwise go to SEARCH. Bad flag clears on every vs_fall.
  - LOCKED:
    - Exits to SEARCH on any line mismatch, a frame-length mismatch at vs_fall, or hcnt saturating at 4095 (lost Hsync).
    - On that transition, sync_err pulses for exactly 1 cycle and locked drops the next cycle.
    - Lost Hsync in CHECK also returns to SEARCH, without sync_err.
- locked = registered (state == LOCKED).
- Active window:
  - h_act = H_ACT_START <= hcnt < H_ACT_START+H_ACTIVE.
  - v_act = V_ACT_START <= vcnt < V_ACT_START+V_ACTIVE.
- de, pix_x, pix_y are registered from hcnt/vcnt: 1 clock after the counter value.
  - de = locked & h_act & v_act.
  - pix_x = hcnt - H_ACT_START when de, else 0; pix_y likewise from vcnt.
- No Vsync ever: FSM stays in SEARCH; counters still run and line_len still updates.
- Reset asserted mid-frame: immediate return to reset values; a fresh SEARCH is required.

Test Plan:
- Standard 800-clock lines (96-clock Hsync low), 525-line frames (2-line Vsync low).
  - Required: line_len = 800, frame_lines = 525.
  - locked asserts after the 3rd vs_fall (1 SEARCH frame + 2 CHECK frames).
  - de is high for 640×480 clocks per frame; pix_x runs 0..639, pix_y 0..479.
- Locked, then a single 799-clock line injected: sync_err one pulse, locked = 0 next cycle, de = 0. Relock after 3 further clean frames.
- Locked, then hsync_in held high: hcnt saturates at 4095, sync_err pulses, locked = 0, line_len holds 800.
- During CHECK, one 524-line frame: return to SEARCH, no sync_err, locked stays 0; lock achieved 3 frames after clean timing resumes.
- Hsync and Vsync falling on the same clock: vcnt = 0, hcnt = 0, frame_lines captures the correct count; no spurious mismatch.
- Reset pulsed mid-frame while locked: all outputs 0 within the reset assertion; state SEARCH; relock after 3 frames.
